rx_packet_deframer: RTL

RX_PACKET_DEFRAMER -- requirements
Module: rx_packet_deframer

---
 rtl/watch_pkg.sv | 25 ++
 rtl/deframer_timeout.sv | 29 ++
 rtl/rx_packet_deframer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the RX packet deframer.
package watch_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  // A length byte is legal when it is non-zero and no larger than max_len.
  function automatic logic len_is_legal(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/deframer_timeout.sv
// Clearable inter-byte timeout counter. expire is a one-cycle pulse in the
// cycle that completes TIMEOUT_CYCLES consecutive cycles without clear.
module deframer_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear in the expiry cycle wins, so a coincident byte suppresses the timeout.
  assign expire = !clear && (count == LAST);

  // Count silent cycles; restart after a clear or after each expiry.
  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/rx_packet_deframer.sv
// RX packet deframer: strips SOF/LEN framing from a UART byte stream and
// forwards payload bytes one cycle after they arrive.
// Optional trailing checksum byte enabled by defining DEFRAMER_CHECKSUM_EN.
module rx_packet_deframer
  import watch_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Pay_DV,
  output logic [7:0] o_Pay_Byte,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  state_t     state;
  logic [7:0] len_q;
  logic [7:0] cnt;
  logic       len_ok;
  logic       last_byte;
  logic       tmo_clear;
  logic       tmo_expire;
`ifdef DEFRAMER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign len_ok    = len_is_legal(i_RX_Byte, MAX_LEN);
  assign last_byte = (cnt == len_q - 8'd1);
  assign tmo_clear = i_RX_DV || (state == ST_IDLE);
  assign o_Busy    = (state != ST_IDLE);

  deframer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .expire(tmo_expire)
  );

  // Frame state machine; a received byte always takes priority over expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      len_q <= '0;
      cnt   <= '0;
    end else if (i_RX_DV) begin
      case (state)
        ST_IDLE: begin
          if (i_RX_Byte == SOF_BYTE) state <= ST_LEN;
        end
        ST_LEN: begin
          if (len_ok) begin
            len_q <= i_RX_Byte;
            cnt   <= '0;
            state <= ST_PAYLOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          cnt <= cnt + 8'd1;
          if (last_byte) begin
`ifdef DEFRAMER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      state <= ST_IDLE;
    end
  end

`ifdef DEFRAMER_CHECKSUM_EN
  // Running modulo-256 sum of payload bytes, restarted on each accepted length.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (i_RX_DV && state == ST_LEN) begin
      sum <= '0;
    end else if (i_RX_DV && state == ST_PAYLOAD) begin
      sum <= sum + i_RX_Byte;
    end
  end
`endif

  // Payload forwarding: registered copy of each payload byte and its strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_Pay_DV   <= 1'b0;
      o_Pay_Byte <= '0;
    end else begin
      o_Pay_DV <= i_RX_DV && (state == ST_PAYLOAD);
      if (i_RX_DV && state == ST_PAYLOAD) o_Pay_Byte <= i_RX_Byte;
    end
  end

  // Completion and error pulses; the error code is held until the next outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_Pkt_Done <= 1'b0;
      o_Pkt_Err  <= 1'b0;
      o_Err_Code <= ERR_NONE;
    end else begin
      o_Pkt_Done <= 1'b0;
      o_Pkt_Err  <= 1'b0;
      if (i_RX_DV) begin
        case (state)
          ST_LEN: begin
            if (!len_ok) begin
              o_Pkt_Err  <= 1'b1;
              o_Err_Code <= ERR_LEN;
            end
          end
`ifndef DEFRAMER_CHECKSUM_EN
          ST_PAYLOAD: begin
            if (last_byte) begin
              o_Pkt_Done <= 1'b1;
              o_Err_Code <= ERR_NONE;
            end
          end
`else
          ST_CHECK: begin
            if (i_RX_Byte == sum) begin
              o_Pkt_Done <= 1'b1;
              o_Err_Code <= ERR_NONE;
            end else begin
              o_Pkt_Err  <= 1'b1;
              o_Err_Code <= ERR_CHK;
            end
          end
`endif
          default: ;
        endcase
      end else if (tmo_expire) begin
        o_Pkt_Err  <= 1'b1;
        o_Err_Code <= ERR_TIMEOUT;
      end
    end
  end

endmodule
